// File: rtl/mem_ctrl_if.sv
// =====================================================================
// mem_ctrl_if : fetch / load-store request ports and 8-bit memory bus, rev 1.0
// =====================================================================
`default_nettype none

interface mem_ctrl_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;

  logic        ls_req;
  logic        ls_wr;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;

  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  modport master (
    output if_req, if_addr, ls_req, ls_wr, ls_size, ls_addr, ls_wdata,
           mem_din, io_buffer_full,
    input  if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );

  modport slave (
    input  if_req, if_addr, ls_req, ls_wr, ls_size, ls_addr, ls_wdata,
           mem_din, io_buffer_full,
    output if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );
endinterface

`default_nettype wire

// File: rtl/mem_ctrl.sv
// =====================================================================
// mem_ctrl : byte-serial memory controller arbitrating fetch and load/store, rev 1.0
// =====================================================================
`default_nettype none

module mem_ctrl #(
  parameter logic [1:0] IO_SEL = 2'b11
) (
  input  wire logic clk_in,
  input  wire logic rst_in,
  input  wire logic rdy_in,
  input  wire logic clear_in,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t      state, state_d;
  logic [31:0] addr, addr_d;
  logic [31:0] wdata, wdata_d;
  logic [31:0] rbuf, rbuf_d;
  logic [2:0]  n, n_d;
  logic [2:0]  iss, iss_d;
  logic [2:0]  cap, cap_d;
  logic        src_ls, src_ls_d;
  logic        io, io_d;
  logic        drv, drv_d;     // a read address is on the bus this cycle
  logic        infl, infl_d;   // mem_din carries the byte addressed last cycle

  logic [31:0] mem_a_d, if_data_d, ls_rdata_d;
  logic [7:0]  mem_dout_d;
  logic        mem_wr_d, if_done_d, ls_done_d;
  logic        ls_io;

  function automatic logic [2:0] size_bytes(input logic [1:0] s);
    case (s)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  always_comb begin
    state_d    = state;
    addr_d     = addr;
    wdata_d    = wdata;
    rbuf_d     = rbuf;
    n_d        = n;
    iss_d      = iss;
    cap_d      = cap;
    src_ls_d   = src_ls;
    io_d       = io;
    drv_d      = drv;
    infl_d     = infl;
    mem_a_d    = bus.mem_a;
    mem_dout_d = bus.mem_dout;
    mem_wr_d   = 1'b0;
    if_done_d  = 1'b0;
    ls_done_d  = 1'b0;
    if_data_d  = bus.if_data;
    ls_rdata_d = bus.ls_rdata;
    ls_io      = (bus.ls_addr[17:16] == IO_SEL);

    if (state == READ && !src_ls && clear_in) begin
      state_d = IDLE;
      mem_a_d = '0;
      iss_d   = '0;
      cap_d   = '0;
      drv_d   = 1'b0;
      infl_d  = 1'b0;
    end else if (!rdy_in) begin
      // Bus lost to the debugger: whatever was driven this cycle never happened.
      drv_d  = 1'b0;
      infl_d = 1'b0;
      if (state == READ)
        iss_d = cap;
      else if (state == WRITE && bus.mem_wr)
        iss_d = iss - 3'd1;
    end else begin
      case (state)
        IDLE: begin
          mem_a_d = '0;
          if (!bus.if_done && !bus.ls_done) begin
            if (bus.ls_req) begin
              addr_d   = bus.ls_addr;
              wdata_d  = bus.ls_wdata;
              n_d      = size_bytes(bus.ls_size);
              src_ls_d = 1'b1;
              io_d     = ls_io;
              rbuf_d   = '0;
              cap_d    = '0;
              infl_d   = 1'b0;
              if (bus.ls_wr) begin
                state_d = WRITE;
                drv_d   = 1'b0;
                if (ls_io && bus.io_buffer_full) begin
                  iss_d = '0;
                end else begin
                  mem_a_d    = bus.ls_addr;
                  mem_dout_d = bus.ls_wdata[7:0];
                  mem_wr_d   = 1'b1;
                  iss_d      = 3'd1;
                end
              end else begin
                state_d = READ;
                mem_a_d = bus.ls_addr;
                iss_d   = 3'd1;
                drv_d   = 1'b1;
              end
            end else if (bus.if_req && !clear_in) begin
              state_d  = READ;
              addr_d   = bus.if_addr;
              n_d      = 3'd4;
              src_ls_d = 1'b0;
              io_d     = 1'b0;
              rbuf_d   = '0;
              cap_d    = '0;
              infl_d   = 1'b0;
              mem_a_d  = bus.if_addr;
              iss_d    = 3'd1;
              drv_d    = 1'b1;
            end
          end
        end

        READ: begin
          if (infl) begin
            rbuf_d[{cap[1:0], 3'b000} +: 8] = bus.mem_din;
            cap_d = cap + 3'd1;
          end
          if (infl && (cap + 3'd1 == n)) begin
            state_d = IDLE;
            mem_a_d = '0;
            iss_d   = '0;
            cap_d   = '0;
            drv_d   = 1'b0;
            infl_d  = 1'b0;
            if (src_ls) begin
              ls_done_d  = 1'b1;
              ls_rdata_d = rbuf_d;
            end else begin
              if_done_d = 1'b1;
              if_data_d = rbuf_d;
            end
          end else begin
            infl_d = drv;
            // IO reads wait until the previous byte has been captured.
            if (iss < n && (!io || !drv)) begin
              mem_a_d = addr + {29'd0, iss};
              iss_d   = iss + 3'd1;
              drv_d   = 1'b1;
            end else begin
              drv_d = 1'b0;
            end
          end
        end

        WRITE: begin
          if (bus.mem_wr && iss == n) begin
            state_d   = IDLE;
            ls_done_d = 1'b1;
            mem_a_d   = '0;
            iss_d     = '0;
          end else if (iss < n) begin
            if (io && bus.io_buffer_full) begin
              mem_a_d = '0;
            end else begin
              mem_a_d    = addr + {29'd0, iss};
              mem_dout_d = wdata[{iss[1:0], 3'b000} +: 8];
              mem_wr_d   = 1'b1;
              iss_d      = iss + 3'd1;
            end
          end
        end

        default: begin
          state_d = IDLE;
          mem_a_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= IDLE;
      addr         <= '0;
      wdata        <= '0;
      rbuf         <= '0;
      n            <= '0;
      iss          <= '0;
      cap          <= '0;
      src_ls       <= 1'b0;
      io           <= 1'b0;
      drv          <= 1'b0;
      infl         <= 1'b0;
      bus.mem_a    <= '0;
      bus.mem_dout <= '0;
      bus.mem_wr   <= 1'b0;
      bus.if_done  <= 1'b0;
      bus.ls_done  <= 1'b0;
      bus.if_data  <= '0;
      bus.ls_rdata <= '0;
    end else begin
      state        <= state_d;
      addr         <= addr_d;
      wdata        <= wdata_d;
      rbuf         <= rbuf_d;
      n            <= n_d;
      iss          <= iss_d;
      cap          <= cap_d;
      src_ls       <= src_ls_d;
      io           <= io_d;
      drv          <= drv_d;
      infl         <= infl_d;
      bus.mem_a    <= mem_a_d;
      bus.mem_dout <= mem_dout_d;
      bus.mem_wr   <= mem_wr_d;
      bus.if_done  <= if_done_d;
      bus.ls_done  <= ls_done_d;
      bus.if_data  <= if_data_d;
      bus.ls_rdata <= ls_rdata_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl.sv
// =====================================================================
// tb_mem_ctrl : directed vector table plus stall/flush/reset sequences, rev 1.0
// =====================================================================
`default_nettype none

module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rst, rdy, clr, mem_init;
  always #5 clk = ~clk;

  mem_ctrl_if bus();

  mem_ctrl #(.IO_SEL(2'b11)) dut (
    .clk_in   (clk),
    .rst_in   (rst),
    .rdy_in   (rdy),
    .clear_in (clr),
    .bus      (bus)
  );

  // RAM/IO model: 1-cycle synchronous read, garbage returned for debugger-owned cycles.
  logic [7:0] ram [0:4095];
  logic [7:0] din_q;

  function automatic logic [11:0] ridx(input logic [31:0] a);
    return {a[17:16], a[9:0]};
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
      ram[4] <= 8'h13;
      ram[5] <= 8'h05;
      din_q  <= 8'h00;
    end else begin
      if (bus.mem_wr && rdy) ram[ridx(bus.mem_a)] <= bus.mem_dout;
      din_q <= rdy ? ram[ridx(bus.mem_a)] : 8'hA5;
    end
  end
  assign bus.mem_din = din_q;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s[%0d]: got %h expected %h", name, idx, got, exp);
  endtask

  // Per-run control schedules: bit c applies to the value sampled at edge E(c).
  logic [63:0] rdy_low_m, full_m, clr_m, rst_m;
  int          ls_start;
  logic [31:0] tr_a    [0:63];
  logic        tr_wr   [0:63];
  logic [7:0]  tr_dout [0:63];
  int          if_lat, ls_lat, wr_cnt, if_done_cnt, ls_done_cnt;
  logic [31:0] if_got, ls_got;

  task automatic apply_ctl(input int c);
    rdy = !rdy_low_m[c];
    bus.io_buffer_full = full_m[c];
    clr = clr_m[c];
    rst = rst_m[c];
  endtask

  task automatic run(input bit do_if, input logic [31:0] ia, input bit do_ls, input bit wr,
                     input logic [1:0] sz, input logic [31:0] la, input logic [31:0] wd,
                     input int min_cyc);
    bit if_p, ls_p;
    @(negedge clk);
    if_lat = -1; ls_lat = -1; wr_cnt = 0; if_done_cnt = 0; ls_done_cnt = 0;
    if_got = '0; ls_got = '0;
    if_p = do_if;
    ls_p = do_ls;
    bus.if_req   = do_if;
    bus.if_addr  = ia;
    bus.ls_wr    = wr;
    bus.ls_size  = sz;
    bus.ls_addr  = la;
    bus.ls_wdata = wd;
    bus.ls_req   = do_ls && (ls_start == 0);
    apply_ctl(0);
    for (int c = 1; c < 64; c++) begin
      @(posedge clk);
      @(negedge clk);
      tr_a[c]    = bus.mem_a;
      tr_wr[c]   = bus.mem_wr;
      tr_dout[c] = bus.mem_dout;
      if (bus.mem_wr) wr_cnt++;
      if (bus.if_done) begin
        if_done_cnt++;
        if (if_p) begin if_lat = c; if_got = bus.if_data; if_p = 0; bus.if_req = 1'b0; end
      end
      if (bus.ls_done) begin
        ls_done_cnt++;
        if (ls_p) begin ls_lat = c; ls_got = bus.ls_rdata; ls_p = 0; bus.ls_req = 1'b0; end
      end
      if (ls_p && c == ls_start) bus.ls_req = 1'b1;
      apply_ctl(c);
      if (clr_m[c]) begin if_p = 0; bus.if_req = 1'b0; end
      if (rst_m[c]) begin if_p = 0; ls_p = 0; bus.if_req = 1'b0; bus.ls_req = 1'b0; end
      if (!if_p && !ls_p && c >= min_cyc) break;
    end
    if (if_p || ls_p) begin
      total++;
      $display("FAIL timeout: if_pending=%0d ls_pending=%0d required 0 0", if_p, ls_p);
      bus.if_req = 1'b0;
      bus.ls_req = 1'b0;
    end
    rdy_low_m = '0; full_m = '0; clr_m = '0; rst_m = '0; ls_start = 0;
    apply_ctl(0);
  endtask

  typedef struct {
    logic        is_ls;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
    int          lat;
    int          wrs;
  } vec_t;

  vec_t vecs [0:13];

  initial begin
    logic [31:0] bw;
    vecs[0]  = '{1'b1, 1'b0, 2'b01, 32'h0000_0102, 32'h0,          1'b1, 32'h0000_DEAD, 4, 0};
    vecs[1]  = '{1'b1, 1'b0, 2'b00, 32'h0000_0101, 32'h0,          1'b1, 32'h0000_00BE, 3, 0};
    vecs[2]  = '{1'b1, 1'b0, 2'b10, 32'h0000_0100, 32'h0,          1'b1, 32'hDEAD_BEEF, 6, 0};
    vecs[3]  = '{1'b1, 1'b1, 2'b01, 32'h0000_0200, 32'hFFFF_1234,  1'b0, 32'h0,         3, 2};
    vecs[4]  = '{1'b1, 1'b0, 2'b10, 32'h0000_0200, 32'h0,          1'b1, 32'h0000_1234, 6, 0};
    vecs[5]  = '{1'b1, 1'b0, 2'b11, 32'h0000_0100, 32'h0,          1'b1, 32'hDEAD_BEEF, 6, 0};
    vecs[6]  = '{1'b1, 1'b1, 2'b00, 32'h0003_0001, 32'h0000_0077,  1'b0, 32'h0,         2, 1};
    vecs[7]  = '{1'b1, 1'b1, 2'b00, 32'h0003_0000, 32'h0000_00AB,  1'b0, 32'h0,         2, 1};
    vecs[8]  = '{1'b1, 1'b0, 2'b01, 32'h0003_0000, 32'h0,          1'b1, 32'h0000_77AB, 5, 0};
    vecs[9]  = '{1'b1, 1'b0, 2'b00, 32'h0003_0001, 32'h0,          1'b1, 32'h0000_0077, 3, 0};
    vecs[10] = '{1'b1, 1'b1, 2'b10, 32'hFFFF_FFFE, 32'h1122_3344,  1'b0, 32'h0,         5, 4};
    vecs[11] = '{1'b1, 1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0,          1'b1, 32'h1122_3344, 9, 0};
    vecs[12] = '{1'b0, 1'b0, 2'b10, 32'h0000_0004, 32'h0,          1'b1, 32'h0000_0513, 6, 0};
    vecs[13] = '{1'b1, 1'b0, 2'b01, 32'h0000_0004, 32'h0,          1'b1, 32'h0000_0513, 4, 0};

    rst = 1'b1; rdy = 1'b1; clr = 1'b0; mem_init = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.ls_req = 1'b0; bus.ls_wr = 1'b0;
    bus.ls_size = '0; bus.ls_addr = '0; bus.ls_wdata = '0; bus.io_buffer_full = 1'b0;
    rdy_low_m = '0; full_m = '0; clr_m = '0; rst_m = '0; ls_start = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_a", 0, bus.mem_a, 32'h0);
    check("rst_ctl", 0, {22'd0, bus.mem_wr, bus.if_done, bus.ls_done, 1'b0, bus.mem_dout}, 32'h0);
    check("rst_if_data", 0, bus.if_data, 32'h0);
    check("rst_ls_rdata", 0, bus.ls_rdata, 32'h0);
    rst = 1'b0;
    mem_init = 1'b0;

    // Word fetch from 0x4.
    run(1'b1, 32'h4, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 0);
    for (int k = 0; k < 4; k++) check("fetch_a", k, tr_a[k+1], 32'(4 + k));
    check("fetch_wr_cnt", 0, 32'(wr_cnt), 32'd0);
    check("fetch_lat", 0, 32'(if_lat), 32'd6);
    check("fetch_data", 0, if_got, 32'h0000_0513);

    // Simultaneous fetch and word store: store wins.
    bw = 32'hDEAD_BEEF;
    run(1'b1, 32'h4, 1'b1, 1'b1, 2'b10, 32'h100, 32'hDEAD_BEEF, 0);
    for (int k = 0; k < 4; k++)
      check("arb_store_byte", k, {7'd0, tr_wr[k+1], tr_dout[k+1], tr_a[k+1][15:0]},
            {7'd0, 1'b1, bw[8*k +: 8], 16'(16'h100 + k)});
    check("arb_ls_lat", 0, 32'(ls_lat), 32'd5);
    check("arb_if_lat", 0, 32'(if_lat), 32'd12);
    check("arb_if_data", 0, if_got, 32'h0000_0513);
    check("arb_pulses", 0, 32'({if_done_cnt[3:0], ls_done_cnt[3:0]}), 32'h11);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_ls)
        run(1'b0, 32'h0, 1'b1, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata, 0);
      else
        run(1'b1, vecs[i].addr, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 0);
      check("vec_lat", i, 32'(vecs[i].is_ls ? ls_lat : if_lat), 32'(vecs[i].lat));
      check("vec_wr_cnt", i, 32'(wr_cnt), 32'(vecs[i].wrs));
      if (vecs[i].chk)
        check("vec_data", i, vecs[i].is_ls ? ls_got : if_got, vecs[i].exp);
    end

    // IO byte store held off by a full UART buffer for five edges.
    full_m = 64'h1F;
    run(1'b0, 32'h0, 1'b1, 1'b1, 2'b00, 32'h0003_0000, 32'h41, 0);
    begin
      int quiet = 1;
      for (int c = 1; c <= 5; c++) if (tr_wr[c] || tr_a[c] != 32'h0) quiet = 0;
      check("full_quiet", 0, 32'(quiet), 32'd1);
    end
    check("full_byte", 0, {tr_wr[6], 7'd0, tr_dout[6], tr_a[6][15:0]}, {1'b1, 7'd0, 8'h41, 16'h0000});
    check("full_a_hi", 0, tr_a[6], 32'h0003_0000);
    check("full_wr_cnt", 0, 32'(wr_cnt), 32'd1);
    check("full_lat", 0, 32'(ls_lat), 32'd7);

    // Word load paused by rdy_in for three edges after two bytes captured.
    rdy_low_m = 64'h70;
    run(1'b0, 32'h0, 1'b1, 1'b0, 2'b10, 32'h100, 32'h0, 0);
    check("rdy_data", 0, ls_got, 32'hDEAD_BEEF);
    check("rdy_lat", 0, 32'(ls_lat), 32'd11);
    check("rdy_reissue2", 0, tr_a[8], 32'h102);
    check("rdy_reissue3", 0, tr_a[9], 32'h103);
    check("rdy_wr_cnt", 0, 32'(wr_cnt), 32'd0);

    // Flush of a fetch while a load waits.
    ls_start = 1;
    clr_m    = 64'h4;
    run(1'b1, 32'h4, 1'b1, 1'b0, 2'b10, 32'h100, 32'h0, 10);
    check("clr_if_done", 0, 32'(if_done_cnt), 32'd0);
    check("clr_ls_a", 0, tr_a[4], 32'h100);
    check("clr_ls_lat", 0, 32'(ls_lat), 32'd9);
    check("clr_ls_data", 0, ls_got, 32'hDEAD_BEEF);

    // Reset in the middle of a word store.
    rst_m = 64'h4;
    run(1'b0, 32'h0, 1'b1, 1'b1, 2'b10, 32'h100, 32'hCAFE_F00D, 6);
    check("rstmid_a", 0, tr_a[3], 32'h0);
    check("rstmid_wr_dout", 0, {23'd0, tr_wr[3], tr_dout[3]}, 32'h0);
    check("rstmid_ls_done", 0, 32'(ls_done_cnt), 32'd0);
    check("rstmid_wr_cnt", 0, 32'(wr_cnt), 32'd2);
    run(1'b0, 32'h0, 1'b1, 1'b0, 2'b10, 32'h100, 32'h0, 0);
    check("rstmid_after", 0, ls_got, 32'hDEAD_F00D);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
